// File: rtl/cache_fill_ctrl_if.sv
// Bundles the miss-request, memory-port and fill-write signals of cache_fill_ctrl.
// The master modport is the fill sequencer; the slave modport is its environment.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        req_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [1:0]        gnt_o;
  logic [1:0]        done_o;
  logic              busy_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              fill_we_o;
  logic [2:0]        fill_word_o;
  logic [DATA_W-1:0] fill_data_o;

  modport master (
    input  req_i, addr0_i, addr1_i, mem_ack_i, mem_rdata_i,
    output gnt_o, done_o, busy_o, mem_req_o, mem_addr_o,
           fill_we_o, fill_word_o, fill_data_o
  );

  modport slave (
    output req_i, addr0_i, addr1_i, mem_ack_i, mem_rdata_i,
    input  gnt_o, done_o, busy_o, mem_req_o, mem_addr_o,
           fill_we_o, fill_word_o, fill_data_o
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Line-fill sequencer: round-robin I/D miss arbitration and an 8-word memory burst into the cache.
// Optional feature macro: CACHE_FILL_CRIT_WORD_FIRST_EN (burst starts at the missed word).
module cache_fill_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  cache_fill_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last;
  logic [1:0]        r_mask;
  logic [1:0]        r_gnt;
  logic [1:0]        r_done;
  logic              r_busy;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-4:0] r_line_base;
  logic [2:0]        r_widx;
  logic [2:0]        r_beat;
  logic              r_fill_we;
  logic [2:0]        r_fill_word;
  logic [DATA_W-1:0] r_fill_data;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_start;
  logic [2:0]        w_widx_nxt;

  // The requester just served sits out the first IDLE cycle after DONE.
  assign w_req = bus.req_i & ~r_mask;

  always_comb begin
    w_gnt = 2'b00;
    case (w_req)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
      2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
      default: w_gnt = 2'b00;
    endcase
  end

  assign w_addr = w_gnt[1] ? bus.addr1_i : bus.addr0_i;

`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
  assign w_start = w_addr[2:0];
`else
  // Offset bits are read but masked off: the burst always starts at word 0.
  assign w_start = w_addr[2:0] & 3'd0;
`endif

  assign w_widx_nxt = r_widx + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b0;
      r_mask      <= 2'b00;
      r_gnt       <= 2'b00;
      r_done      <= 2'b00;
      r_busy      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_line_base <= '0;
      r_widx      <= 3'd0;
      r_beat      <= 3'd0;
      r_fill_we   <= 1'b0;
      r_fill_word <= 3'd0;
      r_fill_data <= '0;
    end else begin
      r_fill_we <= 1'b0;
      r_done    <= 2'b00;
      case (r_state)
        S_IDLE: begin
          r_mask <= 2'b00;
          if (w_gnt != 2'b00) begin
            r_gnt       <= w_gnt;
            r_busy      <= 1'b1;
            r_mem_req   <= 1'b1;
            r_line_base <= w_addr[ADDR_W-1:3];
            r_widx      <= w_start;
            r_beat      <= 3'd0;
            r_mem_addr  <= {w_addr[ADDR_W-1:3], w_start};
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (bus.mem_ack_i) begin
            r_fill_we   <= 1'b1;
            r_fill_word <= r_widx;
            r_fill_data <= bus.mem_rdata_i;
            r_widx      <= w_widx_nxt;
            r_beat      <= r_beat + 3'd1;
            r_mem_addr  <= {r_line_base, w_widx_nxt};
            if (r_beat == 3'd7) begin
              r_mem_req  <= 1'b0;
              r_mem_addr <= '0;
              r_done     <= r_gnt;
              r_state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
          r_last  <= r_gnt[1];
          r_mask  <= r_gnt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt_o       = r_gnt;
  assign bus.done_o      = r_done;
  assign bus.busy_o      = r_busy;
  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.fill_we_o   = r_fill_we;
  assign bus.fill_word_o = r_fill_word;
  assign bus.fill_data_o = r_fill_data;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: arbitration, burst order, wait states, reset and masking.
module tb_cache_fill_ctrl;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  cache_fill_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  cache_fill_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one burst starting in its first BURST cycle; ends sampled in the DONE cycle.
  task automatic do_burst(input logic [1:0] g, input logic [31:0] base,
                          input logic [2:0] start, input bit stall, input int exp_cycles);
    int          beat;
    int          cyc;
    logic [2:0]  w;
    logic [31:0] ea;
    logic [31:0] ed;
    logic        ack;
    beat = 0;
    cyc  = 0;
    while (beat < 8 && cyc < 40) begin
      w  = start + beat[2:0];
      ea = {base[31:3], w};
      ed = 32'hC0DE_0000 ^ (beat << 8) ^ ea;
      n_total++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== ea || bus.gnt_o !== g)
        $display("FAIL burst_addr beat %0d: req=%b addr=%h gnt=%b, want req=1 addr=%h gnt=%b",
                 beat, bus.mem_req_o, bus.mem_addr_o, bus.gnt_o, ea, g);
      else n_pass++;
      ack = stall ? cyc[0] : 1'b1;
      bus.mem_ack_i   = ack;
      bus.mem_rdata_i = ed;
      tick();
      cyc++;
      n_total++;
      if (ack) begin
        if (bus.fill_we_o !== 1'b1 || bus.fill_word_o !== w || bus.fill_data_o !== ed)
          $display("FAIL fill_write beat %0d: we=%b word=%0d data=%h, want we=1 word=%0d data=%h",
                   beat, bus.fill_we_o, bus.fill_word_o, bus.fill_data_o, w, ed);
        else n_pass++;
        beat++;
      end else begin
        if (bus.fill_we_o !== 1'b0)
          $display("FAIL fill_stall beat %0d: we=%b, want 0", beat, bus.fill_we_o);
        else n_pass++;
      end
    end
    bus.mem_ack_i = 1'b0;
    n_total++;
    if (cyc !== exp_cycles)
      $display("FAIL burst_len: %0d BURST cycles, want %0d", cyc, exp_cycles);
    else n_pass++;
    n_total++;
    if (bus.done_o !== g || bus.gnt_o !== g || bus.mem_req_o !== 1'b0 || bus.busy_o !== 1'b1)
      $display("FAIL done_state: done=%b gnt=%b req=%b busy=%b, want done=%b gnt=%b req=0 busy=1",
               bus.done_o, bus.gnt_o, bus.mem_req_o, bus.busy_o, g, g);
    else n_pass++;
  endtask

  task automatic check_idle(input string nm);
    n_total++;
    if (bus.gnt_o !== 2'b00 || bus.done_o !== 2'b00 || bus.busy_o !== 1'b0 || bus.mem_req_o !== 1'b0)
      $display("FAIL %s: gnt=%b done=%b busy=%b req=%b, want all 0",
               nm, bus.gnt_o, bus.done_o, bus.busy_o, bus.mem_req_o);
    else n_pass++;
  endtask

  task automatic check_grant(input string nm, input logic [1:0] g);
    n_total++;
    if (bus.gnt_o !== g || bus.busy_o !== 1'b1 || bus.mem_req_o !== 1'b1)
      $display("FAIL %s: gnt=%b busy=%b req=%b, want gnt=%b busy=1 req=1",
               nm, bus.gnt_o, bus.busy_o, bus.mem_req_o, g);
    else n_pass++;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_i = 2'b00; bus.addr0_i = '0; bus.addr1_i = '0;
    bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
    tick();
    tick();
    n_total++;
    if (bus.gnt_o !== 2'b00 || bus.done_o !== 2'b00 || bus.busy_o !== 1'b0 ||
        bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 32'h0 || bus.fill_we_o !== 1'b0 ||
        bus.fill_word_o !== 3'd0 || bus.fill_data_o !== 32'h0)
      $display("FAIL reset_state: gnt=%b done=%b busy=%b req=%b addr=%h we=%b word=%0d data=%h, want all 0",
               bus.gnt_o, bus.done_o, bus.busy_o, bus.mem_req_o, bus.mem_addr_o,
               bus.fill_we_o, bus.fill_word_o, bus.fill_data_o);
    else n_pass++;
    reset = 1'b0;
    tick();
    check_idle("idle_after_reset");
  endtask

  task automatic test_single();
    bus.req_i = 2'b01; bus.addr0_i = 32'h100;
    tick();
    check_grant("single_grant", 2'b01);
    do_burst(2'b01, 32'h100, 3'd0, 1'b0, 8);
    bus.req_i = 2'b00;
    tick();
    check_idle("single_idle");
  endtask

  task automatic test_contention();
    logic [1:0] g;
    pulse_reset();
    bus.addr0_i = 32'h100; bus.addr1_i = 32'h200;
    bus.req_i = 2'b11;
    g = 2'b10;
    tick();
    check_grant("contend_first", g);
    for (int k = 0; k < 5; k++) begin
      do_burst(g, g[1] ? 32'h200 : 32'h100, 3'd0, 1'b0, 8);
      if (k == 4) bus.req_i = 2'b00;
      tick();
      check_idle("contend_idle");
      if (k < 4) begin
        g = ~g;
        tick();
        check_grant("contend_alt", g);
      end
    end
  endtask

  task automatic test_wait_states();
    tick();
    bus.req_i = 2'b10; bus.addr1_i = 32'h300;
    tick();
    check_grant("wait_grant", 2'b10);
    do_burst(2'b10, 32'h300, 3'd0, 1'b1, 16);
    bus.req_i = 2'b00;
    tick();
    check_idle("wait_idle");
  endtask

  task automatic test_crit_word();
    logic [2:0] st;
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    st = 3'd5;
`else
    st = 3'd0;
`endif
    tick();
    bus.req_i = 2'b10; bus.addr1_i = 32'h23D;
    tick();
    check_grant("cwf_grant", 2'b10);
    do_burst(2'b10, 32'h23D, st, 1'b0, 8);
    bus.req_i = 2'b00;
    tick();
    check_idle("cwf_idle");
  endtask

  task automatic test_reset_mid();
    tick();
    bus.req_i = 2'b01; bus.addr0_i = 32'h100;
    tick();
    check_grant("mid_grant", 2'b01);
    bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 32'h1234_5678;
    tick(); tick(); tick();
    n_total++;
    if (bus.mem_addr_o !== 32'h103)
      $display("FAIL mid_beat3: addr=%h, want 00000103", bus.mem_addr_o);
    else n_pass++;
    reset = 1'b1;
    tick();
    n_total++;
    if (bus.gnt_o !== 2'b00 || bus.done_o !== 2'b00 || bus.busy_o !== 1'b0 ||
        bus.mem_req_o !== 1'b0 || bus.mem_addr_o !== 32'h0 || bus.fill_we_o !== 1'b0 ||
        bus.fill_word_o !== 3'd0 || bus.fill_data_o !== 32'h0)
      $display("FAIL mid_reset: gnt=%b done=%b busy=%b req=%b addr=%h we=%b word=%0d data=%h, want all 0",
               bus.gnt_o, bus.done_o, bus.busy_o, bus.mem_req_o, bus.mem_addr_o,
               bus.fill_we_o, bus.fill_word_o, bus.fill_data_o);
    else n_pass++;
    reset = 1'b0;
    bus.mem_ack_i = 1'b0;
    bus.req_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("mid_no_done");
    end
    bus.req_i = 2'b01;
    tick();
    check_grant("mid_restart", 2'b01);
    do_burst(2'b01, 32'h100, 3'd0, 1'b0, 8);
    bus.req_i = 2'b00;
    tick();
    check_idle("mid_idle");
  endtask

  task automatic test_hold_mask();
    tick();
    bus.req_i = 2'b01; bus.addr0_i = 32'h140;
    tick();
    check_grant("hold_grant", 2'b01);
    do_burst(2'b01, 32'h140, 3'd0, 1'b0, 8);
    tick();
    check_idle("hold_masked");
    tick();
    check_idle("hold_sample");
    tick();
    check_grant("hold_regrant", 2'b01);
    bus.req_i = 2'b00;
    do_burst(2'b01, 32'h140, 3'd0, 1'b0, 8);
    tick();
    check_idle("hold_idle");
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single();
    test_contention();
    test_wait_states();
    test_crit_word();
    test_reset_mid();
    test_hold_mask();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
